// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, FSM encodings, Rcon and GF(2^8) helpers
// used by the iterative decryptor and its S-box sub-modules.
package aes_pkg;

    localparam int AES_W = 128;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KEYEXP = 2'd1;
    localparam logic [1:0] ST_ROUNDS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Index 0 is unused so that Rcon[i] lines up with FIPS-197 numbering.
    localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                            8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Byte i of a block sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [AES_W-1:0] inv_shift_rows(input logic [AES_W-1:0] s);
        logic [AES_W-1:0] r_out;
        r_out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                r_out[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return r_out;
    endfunction

    function automatic logic [AES_W-1:0] inv_mix_columns(input logic [AES_W-1:0] s);
        logic [AES_W-1:0] m;
        logic [7:0] a0, a1, a2, a3;
        m = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            m[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            m[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            m[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            m[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return m;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by the GF(2^8) inverse.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] y;

    assign y = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    assign s = gf_inv(y);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] b;

    assign b = gf_inv(a);
    assign s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to rk10, then runs one
// inverse round per clock while unrolling the key schedule backwards.
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AES_W-1:0] cipher_in,
    input  logic [AES_W-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AES_W-1:0] plaintext_out,
    output logic             busy
);

    logic [1:0]       state;
    logic [AES_W-1:0] state_reg;
    logic [AES_W-1:0] key_reg;
    logic [3:0]       cnt;
    logic [3:0]       rnd;

    logic [31:0]      rot_src, sb_in, sb_out;
    logic [31:0]      temp_fwd, temp_inv;
    logic [AES_W-1:0] key_fwd, key_inv;
    logic [AES_W-1:0] isr, isb, add_rk, round_out;

    // Both key steps need SubWord(RotWord(w)); only the source word differs.
    // Going backwards, the previous w3 is recovered as w3' = n3 ^ n2.
    assign rot_src = (state == ST_ROUNDS) ? (key_reg[31:0] ^ key_reg[63:32]) : key_reg[31:0];
    assign sb_in   = {rot_src[23:0], rot_src[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(sb_in[8*i +: 8]), .s(sb_out[8*i +: 8]));
    end

    assign temp_fwd = sb_out ^ {RCON[cnt], 24'h0};
    assign temp_inv = sb_out ^ {RCON[rnd + 4'd1], 24'h0};

    assign key_fwd[127:96] = key_reg[127:96] ^ temp_fwd;
    assign key_fwd[95:64]  = key_reg[95:64]  ^ key_fwd[127:96];
    assign key_fwd[63:32]  = key_reg[63:32]  ^ key_fwd[95:64];
    assign key_fwd[31:0]   = key_reg[31:0]   ^ key_fwd[63:32];

    assign key_inv[31:0]   = key_reg[31:0]   ^ key_reg[63:32];
    assign key_inv[63:32]  = key_reg[63:32]  ^ key_reg[95:64];
    assign key_inv[95:64]  = key_reg[95:64]  ^ key_reg[127:96];
    assign key_inv[127:96] = key_reg[127:96] ^ temp_inv;

    assign isr = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.a(isr[8*i +: 8]), .s(isb[8*i +: 8]));
    end

    assign add_rk    = isb ^ key_inv;
    assign round_out = (rnd == 4'd0) ? add_rk : inv_mix_columns(add_rk);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational paths above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            cnt       <= '0;
            rnd       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_reg <= cipher_in;
                        key_reg   <= key_in;
                        cnt       <= 4'd1;
                        state     <= ST_KEYEXP;
                    end
                end
                ST_KEYEXP: begin
                    key_reg <= key_fwd;
                    if (cnt == 4'd10) begin
                        state_reg <= state_reg ^ key_fwd;
                        rnd       <= 4'd9;
                        state     <= ST_ROUNDS;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ROUNDS: begin
                    key_reg   <= key_inv;
                    state_reg <= round_out;
                    if (rnd == 4'd0) state <= ST_DONE;
                    else             rnd   <= rnd - 4'd1;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = (state == ST_IDLE);
    assign out_valid     = (state == ST_DONE);
    assign busy          = (state == ST_KEYEXP) || (state == ST_ROUNDS);
    // Intermediate round state never leaks onto the output bus.
    assign plaintext_out = out_valid ? state_reg : '0;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors, handshake corner
// cases, and loopback against a behavioural AES-128 encryptor.
module tb_aes_decrypt_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext_out;
    logic         busy;

    int passed = 0;
    int total  = 0;

    logic [7:0] sbox_t [256];

    aes_decrypt_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cipher_in    (cipher_in),
        .key_in       (key_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .plaintext_out(plaintext_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s, rk, t;
        logic [31:0]  w3, tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = key;
        s  = pt ^ rk;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            t = '0;
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[127-8*(row+4*c) -: 8] = sbox_t[s[127-8*(row+4*((c+row)%4)) -: 8]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
                    t[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            w3  = rk[31:0];
            tmp = {sbox_t[w3[23:16]] ^ rc, sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]};
            rk[127:96] = rk[127:96] ^ tmp;
            rk[95:64]  = rk[95:64]  ^ rk[127:96];
            rk[63:32]  = rk[63:32]  ^ rk[95:64];
            rk[31:0]   = rk[31:0]   ^ rk[63:32];
            rc = xt(rc);
            s  = t ^ rk;
        end
        return s;
    endfunction

    // Presents a job for one cycle; returns at the first negedge after acceptance.
    task automatic start_job(input logic [127:0] k, input logic [127:0] c);
        @(negedge clk);
        in_valid  = 1'b1;
        key_in    = k;
        cipher_in = c;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // lat counts cycles after the accept cycle: the first KEYEXP cycle is 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t         vecs[2];
        int           lat;
        logic [127:0] got, k, p, c;
        logic         ok;

        vecs[0] = '{"fips_c1",   C1_KEY, C1_CT, C1_PT};
        vecs[1] = '{"fips_appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                                 128'h3925841d02dc09fbdc118597196a0b32,
                                 128'h3243f6a8885a308d313198a2e0370734};

        build_sbox();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cipher_in = '0;
        key_in    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_in_ready",  in_ready,      1);
        check("reset_out_valid", out_valid,     0);
        check("reset_busy",      busy,          0);
        check("reset_plaintext", plaintext_out, 0);

        for (int i = 0; i < 2; i++) begin
            start_job(vecs[i].key, vecs[i].ct);
            check({vecs[i].name, "_busy"},     busy,     1);
            check({vecs[i].name, "_in_ready"}, in_ready, 0);
            wait_done(lat);
            check({vecs[i].name, "_latency"},  lat,      21);
            check({vecs[i].name, "_pt"},       plaintext_out, vecs[i].pt);
            check({vecs[i].name, "_busy_done"}, busy,    0);
            take_result();
            check({vecs[i].name, "_idle"},     in_ready, 1);
        end

        // Back-pressure: the result must sit still for 50 cycles.
        start_job(C1_KEY, C1_CT);
        wait_done(lat);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (plaintext_out !== C1_PT || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        check("backpressure_hold", ok, 1);
        take_result();
        check("backpressure_release_in_ready",  in_ready,  1);
        check("backpressure_release_out_valid", out_valid, 0);

        // Inputs churn every cycle of the job, including spurious in_valid.
        start_job(C1_KEY, C1_CT);
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid  = 1'($urandom_range(0, 1));
            cipher_in = {$urandom, $urandom, $urandom, $urandom};
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("toggle_latency", lat, 21);
        check("toggle_pt", plaintext_out, C1_PT);
        take_result();

        // Asynchronous reset in the middle of the ROUNDS phase.
        start_job(C1_KEY, C1_CT);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready",  in_ready,      1);
        check("midreset_out_valid", out_valid,     0);
        check("midreset_busy",      busy,          0);
        check("midreset_plaintext", plaintext_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || plaintext_out !== '0) ok = 1'b0;
        end
        check("midreset_no_output", ok, 1);
        start_job(C1_KEY, C1_CT);
        wait_done(lat);
        check("after_reset_pt", plaintext_out, C1_PT);
        take_result();

        // Loopback from the behavioural encryptor.
        for (int i = 0; i < 100; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            c = aes_encrypt(k, p);
            start_job(k, c);
            wait_done(lat);
            got = plaintext_out;
            check($sformatf("loopback_%0d", i), got, p);
            take_result();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
